// File: rtl/ber_accumulator.sv
// ber_accumulator
// Gathers word, bit and error totals from a PRBS checker over a measurement
// window. A run is started with a one-cycle start pulse. The block then waits
// for checker lock, with a timeout. Once locked it accumulates qualified words
// until one of four things ends the run: the window completes, lock is lost,
// the run is aborted, or the lock wait times out. The totals and a status
// code are then held in REPORT until the consumer accepts them.
module ber_accumulator #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 48,
  parameter int WIN_W   = 32,
  parameter int LOCK_TO = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             lock,
  input  logic [WIDTH:0]   err_num,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIN_W-1:0] word_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       status
);

  // The timeout counter only has to reach LOCK_TO-1. The run leaves
  // WAIT_LOCK on that cycle whatever else happens.
  localparam int TO_W = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TO - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [CNT_W:0]  BIT_STEP = (CNT_W + 1)'(WIDTH);
  localparam logic [WIN_W:0]  WORD_ONE = (WIN_W + 1)'(1);

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_LOST    = 2'b10;
  localparam logic [1:0] STAT_ABORT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_MEASURE   = 2'd2,
    ST_REPORT    = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIN_W-1:0] window_len_reg;
  logic [WIN_W-1:0] word_cnt_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic [1:0]       status_reg;
  logic [1:0]       status_next;
  logic [TO_W-1:0]  to_cnt_reg;

  logic             accept_start;
  logic             count_word;
  logic             load_status;

  // The sums carry one extra bit. A set top bit means the counter would
  // wrap, so the counter saturates at all-ones instead.
  logic [WIN_W:0]   word_sum;
  logic [CNT_W:0]   bit_sum;
  logic [CNT_W:0]   err_sum;
  logic             window_done;
  logic             lock_timeout;

  assign word_sum = {1'b0, word_cnt_reg} + WORD_ONE;
  assign bit_sum  = {1'b0, bit_cnt_reg} + BIT_STEP;
  assign err_sum  = {1'b0, err_cnt_reg} + (CNT_W + 1)'(err_num);

  // The word being counted this cycle is the last one of the window. A
  // zero window length means the run is continuous.
  assign window_done  = (window_len_reg != '0) && (word_sum == {1'b0, window_len_reg});
  assign lock_timeout = (to_cnt_reg == TO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. In the active states, abort is checked first, then
  // lock, then the word itself.
  always_comb begin
    state_next   = state_reg;
    accept_start = 1'b0;
    count_word   = 1'b0;
    load_status  = 1'b0;
    status_next  = STAT_OK;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (abort) begin
          load_status = 1'b1;
          status_next = STAT_ABORT;
          state_next  = ST_REPORT;
        end else if (lock) begin
          state_next = ST_MEASURE;
        end else if (lock_timeout) begin
          load_status = 1'b1;
          status_next = STAT_TIMEOUT;
          state_next  = ST_REPORT;
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          load_status = 1'b1;
          status_next = STAT_ABORT;
          state_next  = ST_REPORT;
        end else if (!lock) begin
          load_status = 1'b1;
          status_next = STAT_LOST;
          state_next  = ST_REPORT;
        end else if (en) begin
          count_word = 1'b1;
          if (window_done) begin
            load_status = 1'b1;
            status_next = STAT_OK;
            state_next  = ST_REPORT;
          end
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state_reg)
      ST_WAIT_LOCK, ST_MEASURE: busy      = 1'b1;
      ST_REPORT:                res_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulators, latched window, lock timeout and status. The results
  // stay put in REPORT and IDLE until the next accepted start clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_len_reg <= '0;
      word_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      err_cnt_reg    <= '0;
      status_reg     <= STAT_OK;
      to_cnt_reg     <= '0;
    end else if (accept_start) begin
      window_len_reg <= window_len;
      word_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      err_cnt_reg    <= '0;
      status_reg     <= STAT_OK;
      to_cnt_reg     <= '0;
    end else begin
      if ((state_reg == ST_WAIT_LOCK) && !lock_timeout) begin
        to_cnt_reg <= to_cnt_reg + TO_ONE;
      end
      if (count_word) begin
        word_cnt_reg <= word_sum[WIN_W] ? '1 : word_sum[WIN_W-1:0];
        bit_cnt_reg  <= bit_sum[CNT_W]  ? '1 : bit_sum[CNT_W-1:0];
        err_cnt_reg  <= err_sum[CNT_W]  ? '1 : err_sum[CNT_W-1:0];
      end
      if (load_status) begin
        status_reg <= status_next;
      end
    end
  end

  assign word_cnt = word_cnt_reg;
  assign bit_cnt  = bit_cnt_reg;
  assign err_cnt  = err_cnt_reg;
  assign status   = status_reg;

endmodule

// File: tb/tb_ber_accumulator.sv
// Testbench for ber_accumulator. It has three parts. The first is a table of
// measurement scenarios with expected totals. The second is a set of
// hand-written multi-cycle corner cases. The third is randomized runs checked
// against a behavioural model. A second, narrow instance is used to check
// counter saturation.
module tb_ber_accumulator;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 48;
  localparam int WIN_W   = 32;
  localparam int LOCK_TO = 16;

  localparam int S_WIDTH   = 4;
  localparam int S_CNT_W   = 8;
  localparam int S_WIN_W   = 8;
  localparam int S_LOCK_TO = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0, lock = 1'b0, start = 1'b0, abort = 1'b0, res_ready = 1'b0;
  logic [WIDTH:0]   err_num = '0;
  logic [WIN_W-1:0] window_len = '0;
  logic             busy, res_valid;
  logic [WIN_W-1:0] word_cnt;
  logic [CNT_W-1:0] bit_cnt, err_cnt;
  logic [1:0]       status;

  logic               s_en = 1'b0, s_lock = 1'b0, s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b0;
  logic [S_WIDTH:0]   s_err = '0;
  logic [S_WIN_W-1:0] s_win = '0;
  logic               s_busy, s_res_valid;
  logic [S_WIN_W-1:0] s_word;
  logic [S_CNT_W-1:0] s_bit, s_errc;
  logic [1:0]         s_status;

  ber_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W), .LOCK_TO(LOCK_TO)) dut (
    .clk(clk), .reset(reset), .en(en), .lock(lock), .err_num(err_num),
    .start(start), .abort(abort), .window_len(window_len), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .word_cnt(word_cnt),
    .bit_cnt(bit_cnt), .err_cnt(err_cnt), .status(status)
  );

  ber_accumulator #(.WIDTH(S_WIDTH), .CNT_W(S_CNT_W), .WIN_W(S_WIN_W), .LOCK_TO(S_LOCK_TO)) dut_small (
    .clk(clk), .reset(reset), .en(s_en), .lock(s_lock), .err_num(s_err),
    .start(s_start), .abort(s_abort), .window_len(s_win), .busy(s_busy),
    .res_valid(s_res_valid), .res_ready(s_ready), .word_cnt(s_word),
    .bit_cnt(s_bit), .err_cnt(s_errc), .status(s_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit lock;
    bit abort;
    int err;
  } stim_t;

  typedef struct {
    string  name;
    int     win;
    int     lock_delay;
    int     gap_lo;
    int     gap_len;
    int     err_val;
    int     err_words;
    int     drop_at;
    int     abort_at;
    longint exp_words;
    longint exp_bits;
    longint exp_errs;
    int     exp_status;
    int     exp_end;
  } vec_t;

  typedef struct {
    int     end_idx;
    longint words;
    longint bits;
    longint errs;
    int     status;
  } res_t;

  stim_t stim_q[$];
  vec_t  tbl[11];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  // Behavioural reference. The run begins in the lock wait at stimulus index
  // 0. Abort ends it at once. Before lock, LOCK_TO lock-less cycles end it.
  // After lock, a lock drop ends it, and otherwise every qualified word
  // counts, with saturation, until the window is full.
  function automatic res_t model(input longint win, input int lock_to, input int width,
                                 input longint word_max, input longint cnt_max);
    res_t  r;
    stim_t s;
    bit    locked;
    locked = 1'b0;
    r = '{end_idx: -1, words: 0, bits: 0, errs: 0, status: 0};
    for (int k = 0; k < stim_q.size(); k++) begin
      s = stim_q[k];
      if (s.abort) begin
        r.status = 3; r.end_idx = k; return r;
      end
      if (!locked) begin
        if (s.lock) locked = 1'b1;
        else if (k == lock_to - 1) begin
          r.status = 1; r.end_idx = k; return r;
        end
      end else if (!s.lock) begin
        r.status = 2; r.end_idx = k; return r;
      end else if (s.en) begin
        r.words = lmin(r.words + 1, word_max);
        r.bits  = lmin(r.bits + width, cnt_max);
        r.errs  = lmin(r.errs + s.err, cnt_max);
        if (win != 0 && r.words == win) begin
          r.status = 0; r.end_idx = k; return r;
        end
      end
    end
    return r;
  endfunction

  // Builds the per-cycle stimulus for one table scenario. The lock-gaining
  // cycle carries a nonzero err_num to show that it is not accumulated.
  task automatic gen_stim(input vec_t v);
    stim_t s;
    int    counted;
    int    m;
    stim_q.delete();
    for (int i = 0; i < v.lock_delay; i++) stim_q.push_back('{en: 1'b1, lock: 1'b0, abort: 1'b0, err: 0});
    stim_q.push_back('{en: 1'b1, lock: 1'b1, abort: 1'b0, err: 7});
    counted = 0;
    m = 0;
    while (stim_q.size() < 400) begin
      s.en    = !(m >= v.gap_lo && m < v.gap_lo + v.gap_len);
      s.lock  = (counted != v.drop_at);
      s.abort = (counted == v.abort_at);
      s.err   = (counted < v.err_words) ? v.err_val : 0;
      stim_q.push_back(s);
      m++;
      if (!s.lock || s.abort) break;
      if (s.en) counted++;
      if (v.win != 0 && counted == v.win) break;
    end
  endtask

  // Starts a run and applies stim_q one element per cycle until the result
  // appears. Changing window_len after start shows that the value was latched.
  task automatic run_seq(input int win, output int end_idx);
    window_len = WIN_W'(win);
    start = 1'b1;
    step();
    start = 1'b0;
    window_len = $urandom;
    check("busy_after_start", 64'(busy), 64'd1);
    end_idx = -1;
    for (int k = 0; k < stim_q.size(); k++) begin
      en = stim_q[k].en; lock = stim_q[k].lock; abort = stim_q[k].abort;
      err_num = (WIDTH + 1)'(stim_q[k].err);
      step();
      if (res_valid) begin
        end_idx = k;
        break;
      end
    end
    en = 1'b0; lock = 1'b0; abort = 1'b0; err_num = '0;
  endtask

  task automatic check_result(input string name, input int end_idx, input res_t e);
    $display("run %s: end=%0d words=%0d bits=%0d errs=%0d status=%0d (want end=%0d %0d/%0d/%0d/%0d)",
             name, end_idx, word_cnt, bit_cnt, err_cnt, status,
             e.end_idx, e.words, e.bits, e.errs, e.status);
    check({name, ".end"},    64'(end_idx), 64'(e.end_idx));
    check({name, ".valid"},  64'(res_valid), 64'd1);
    check({name, ".words"},  64'(word_cnt), 64'(e.words));
    check({name, ".bits"},   64'(bit_cnt), 64'(e.bits));
    check({name, ".errs"},   64'(err_cnt), 64'(e.errs));
    check({name, ".status"}, 64'(status), 64'(e.status));
  endtask

  // Completes the handshake and checks that the totals survive into IDLE.
  // If no result ever appeared, reset clears the DUT for the next run.
  task automatic close_run(input string name, input longint exp_words);
    if (res_valid) begin
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check({name, ".idle_valid"}, 64'(res_valid), 64'd0);
      check({name, ".idle_busy"},  64'(busy), 64'd0);
      check({name, ".idle_words"}, 64'(word_cnt), 64'(exp_words));
    end else begin
      reset = 1'b1;
      step();
      reset = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   end_idx;
    res_t e;
    vec_t v;

    //            name                  win ld gl gn  ev  ew  drop abort words bits errs  st end
    tbl[0]  = '{"win100",              100, 0, 0, 0,   0,  0, -1, -1, 100, 800,    0, 0, 100};
    tbl[1]  = '{"gap",                  10, 0, 3, 4,   3,  5, -1, -1,  10,  80,   15, 0,  14};
    tbl[2]  = '{"lockloss",            100, 0, 0, 0,   0,  0, 50, -1,  50, 400,    0, 2,  51};
    tbl[3]  = '{"abort_and_lockloss",  100, 0, 0, 0,   0,  0, 50, 50,  50, 400,    0, 3,  51};
    tbl[4]  = '{"abort_vs_window",       8, 0, 0, 0,   0,  0, -1,  7,   7,  56,    0, 3,   8};
    tbl[5]  = '{"lockloss_vs_window",    5, 0, 0, 0,   0,  0,  4, -1,   4,  32,    0, 2,   5};
    tbl[6]  = '{"win1",                  1, 0, 0, 0, 255,  1, -1, -1,   1,   8,  255, 0,   1};
    tbl[7]  = '{"errmax",                3, 0, 0, 0, 511,  3, -1, -1,   3,  24, 1533, 0,   3};
    tbl[8]  = '{"lock_delay",            4, 5, 0, 0,   2,  4, -1, -1,   4,  32,    8, 0,   9};
    tbl[9]  = '{"continuous_abort",      0, 0, 0, 0,   1, 20, -1, 20,  20, 160,   20, 3,  21};
    tbl[10] = '{"timeout",               7,20, 0, 0,   0,  0, -1, -1,   0,   0,    0, 1,  15};

    repeat (3) step();
    reset = 1'b0;
    check("reset.busy",   64'(busy), 64'd0);
    check("reset.valid",  64'(res_valid), 64'd0);
    check("reset.words",  64'(word_cnt), 64'd0);
    check("reset.bits",   64'(bit_cnt), 64'd0);
    check("reset.errs",   64'(err_cnt), 64'd0);
    check("reset.status", 64'(status), 64'd0);

    // Abort in IDLE must not start anything.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort.busy",  64'(busy), 64'd0);
    check("idle_abort.valid", 64'(res_valid), 64'd0);

    // Table-driven scenarios
    for (int i = 0; i < 11; i++) begin
      gen_stim(tbl[i]);
      run_seq(tbl[i].win, end_idx);
      e = '{end_idx: tbl[i].exp_end, words: tbl[i].exp_words, bits: tbl[i].exp_bits,
            errs: tbl[i].exp_errs, status: tbl[i].exp_status};
      check_result(tbl[i].name, end_idx, e);
      close_run(tbl[i].name, tbl[i].exp_words);
    end

    // Abort on the final timeout cycle: abort wins.
    stim_q.delete();
    repeat (15) stim_q.push_back('{en: 1'b1, lock: 1'b0, abort: 1'b0, err: 0});
    stim_q.push_back('{en: 1'b1, lock: 1'b0, abort: 1'b1, err: 0});
    run_seq(5, end_idx);
    check_result("abort_vs_timeout", end_idx, '{end_idx: 15, words: 0, bits: 0, errs: 0, status: 3});
    close_run("abort_vs_timeout", 0);

    // Lock arriving on the last allowed cycle still enters MEASURE.
    stim_q.delete();
    repeat (15) stim_q.push_back('{en: 1'b1, lock: 1'b0, abort: 1'b0, err: 0});
    stim_q.push_back('{en: 1'b1, lock: 1'b1, abort: 1'b0, err: 0});
    repeat (2) stim_q.push_back('{en: 1'b1, lock: 1'b1, abort: 1'b0, err: 5});
    run_seq(2, end_idx);
    check_result("late_lock", end_idx, '{end_idx: 17, words: 2, bits: 16, errs: 10, status: 0});
    close_run("late_lock", 2);

    // Consumer stall: the result holds while start, abort and new words are ignored.
    v = '{"stall", 3, 0, 0, 0, 4, 3, -1, -1, 3, 24, 12, 0, 3};
    gen_stim(v);
    run_seq(3, end_idx);
    check_result("stall", end_idx, '{end_idx: 3, words: 3, bits: 24, errs: 12, status: 0});
    start = 1'b1; abort = 1'b1; en = 1'b1; lock = 1'b1; err_num = 9'd9;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("stall.c%0d.valid", c),  64'(res_valid), 64'd1);
      check($sformatf("stall.c%0d.busy", c),   64'(busy), 64'd0);
      check($sformatf("stall.c%0d.words", c),  64'(word_cnt), 64'd3);
      check($sformatf("stall.c%0d.bits", c),   64'(bit_cnt), 64'd24);
      check($sformatf("stall.c%0d.errs", c),   64'(err_cnt), 64'd12);
      check($sformatf("stall.c%0d.status", c), 64'(status), 64'd0);
    end
    start = 1'b0; abort = 1'b0; en = 1'b0; lock = 1'b0; err_num = '0;
    close_run("stall", 3);
    step();
    check("stall.after_busy", 64'(busy), 64'd0);
    $display("run stall: 10 held cycles, then handshake");

    // Reset in the middle of a measurement discards everything.
    window_len = 32'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1; lock = 1'b1;
    repeat (31) step();
    check("midreset.words_before", 64'(word_cnt), 64'd30);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset.busy",   64'(busy), 64'd0);
    check("midreset.valid",  64'(res_valid), 64'd0);
    check("midreset.words",  64'(word_cnt), 64'd0);
    check("midreset.bits",   64'(bit_cnt), 64'd0);
    check("midreset.errs",   64'(err_cnt), 64'd0);
    check("midreset.status", 64'(status), 64'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("midreset.c%0d.valid", c), 64'(res_valid), 64'd0);
      check($sformatf("midreset.c%0d.busy", c),  64'(busy), 64'd0);
    end
    en = 1'b0; lock = 1'b0;
    v = '{"after_reset", 5, 0, 0, 0, 6, 2, -1, -1, 5, 40, 12, 0, 5};
    gen_stim(v);
    run_seq(5, end_idx);
    check_result("after_reset", end_idx, '{end_idx: 5, words: 5, bits: 40, errs: 12, status: 0});
    close_run("after_reset", 5);

    // Randomized runs against the behavioural model
    for (int t = 0; t < 30; t++) begin
      int    win;
      int    ld;
      stim_t s;
      stim_q.delete();
      win = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 40));
      ld  = int'($urandom_range(0, 20));
      for (int k = 0; k < 80; k++) begin
        s.lock  = (k < ld) ? 1'b0 : ($urandom_range(0, 99) >= 3);
        s.en    = ($urandom_range(0, 3) != 0);
        s.err   = int'($urandom_range(0, 511));
        s.abort = ($urandom_range(0, 99) < 2) || (k == 79);
        stim_q.push_back(s);
      end
      e = model(win, LOCK_TO, WIDTH, (64'd1 << WIN_W) - 1, (64'd1 << CNT_W) - 1);
      run_seq(win, end_idx);
      check_result($sformatf("rand%0d_win%0d", t, win), end_idx, e);
      close_run($sformatf("rand%0d", t), e.words);
    end

    // Saturation on the narrow instance: continuous run with maximum errors.
    s_win = '0;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    s_lock = 1'b1; s_en = 1'b1; s_err = 5'd31;
    step();
    for (int w = 1; w <= 300; w++) begin
      step();
      if (w inside {5, 8, 9, 63, 64, 100, 255, 300}) begin
        $display("sat w=%0d: words=%0d bits=%0d errs=%0d", w, s_word, s_bit, s_errc);
        check($sformatf("sat.w%0d.words", w), 64'(s_word), 64'(lmin(w, 255)));
        check($sformatf("sat.w%0d.bits", w),  64'(s_bit),  64'(lmin(4 * w, 255)));
        check($sformatf("sat.w%0d.errs", w),  64'(s_errc), 64'(lmin(31 * w, 255)));
        check($sformatf("sat.w%0d.busy", w),  64'(s_busy), 64'd1);
      end
    end
    s_abort = 1'b1;
    step();
    s_abort = 1'b0; s_en = 1'b0; s_lock = 1'b0; s_err = '0;
    check("sat.end.valid",  64'(s_res_valid), 64'd1);
    check("sat.end.status", 64'(s_status), 64'd3);
    check("sat.end.words",  64'(s_word), 64'd255);
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    check("sat.idle.valid", 64'(s_res_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ber_accumulator.md
BER_ACCUMULATOR -- requirements
Module: ber_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning PRBS word width seen by the checker (bits per word).
REQ-002 SHALL have parameter CNT_W, default 48, meaning width of the bit and error accumulators.
REQ-003 SHALL have parameter WIN_W, default 32, meaning width of the window length and word counter.
REQ-004 SHALL have parameter LOCK_TO, default 1024, meaning lock wait timeout in clock cycles.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 en  input  1  word-valid qualifier, same as the checker enable.
REQ-009 lock  input  1  checker lock indication.
REQ-010 err_num  input  WIDTH+1  per-word error count from the checker.
REQ-011 start  input  1  one-cycle pulse that begins a measurement; honoured only in IDLE.
REQ-012 abort  input  1  terminates the measurement in WAIT_LOCK or MEASURE.
REQ-013 window_len  input  WIN_W  words to measure; latched on accepted start.
REQ-014 busy  output  1  high in WAIT_LOCK and MEASURE.
REQ-015 res_valid  output  1  result available (REPORT state).
REQ-016 res_ready  input  1  result consumer ready.
REQ-017 word_cnt  output  WIN_W  qualified words counted.
REQ-018 bit_cnt  output  CNT_W  bits counted (word_cnt x WIDTH).
REQ-019 err_cnt  output  CNT_W  accumulated errors.
REQ-020 status  output  2  00 OK, 01 lock timeout, 10 lock lost, 11 aborted.

Function
REQ-021 SHALL implement the FSM states IDLE, WAIT_LOCK, MEASURE and REPORT.
REQ-022 IDLE: on start=1, SHALL clear the counters and status, latch window_len, start the timeout counter, and go to WAIT_LOCK next cycle.
REQ-023 WAIT_LOCK: on lock=1, SHALL go to MEASURE; the first word is accumulated in the cycle after entry.
REQ-024 WAIT_LOCK: after LOCK_TO cycles without lock, SHALL go to REPORT with status=01.
REQ-025 MEASURE: each cycle with en=1 and lock=1, SHALL increment word_cnt by 1, add WIDTH to bit_cnt, and add err_num to err_cnt (zero-extended), registered with 1-cycle latency.
REQ-026 MEASURE: cycles with en=0 SHALL leave all counters unchanged and SHALL NOT count toward the window.
REQ-027 MEASURE: when the accumulated word equals the latched window_len, SHALL go to REPORT with status=00; that word is included.
REQ-028 window_len=0 SHALL mean continuous measurement until abort or lock loss.
REQ-029 MEASURE: lock=0 SHALL go to REPORT with status=10, and that cycle's word is not counted.
REQ-030 abort=1 in WAIT_LOCK or MEASURE SHALL go to REPORT with status=11, and that cycle's word is not counted.
REQ-031 Abort SHALL take priority over lock loss, window completion and timeout in the same cycle.
REQ-032 err_cnt and bit_cnt SHALL saturate at all-ones rather than wrap.
REQ-033 word_cnt SHALL NOT wrap, since the window terminates it; in continuous mode it SHALL saturate at all-ones.
REQ-034 REPORT: res_valid=1, and word_cnt, bit_cnt, err_cnt and status SHALL stay stable until res_ready=1.
REQ-035 REPORT: on the res_valid and res_ready handshake, SHALL return to IDLE next cycle.
REQ-036 REPORT: counters SHALL keep their values in IDLE until the next accepted start.
REQ-037 start outside IDLE SHALL be ignored; abort in IDLE or REPORT SHALL be ignored.
REQ-038 busy SHALL be combinational from the state register.

Reset
REQ-039 reset=1 SHALL force IDLE from any state; busy=0, res_valid=0, word_cnt=0, bit_cnt=0, err_cnt=0, status=00 on the next edge.
REQ-040 Reset mid-measurement SHALL discard the partial result, with no res_valid pulse.

Verification
REQ-041 WIDTH=8, window_len=100, lock=1, en=1, err_num=0 -> res_valid with word_cnt=100, bit_cnt=800, err_cnt=0, status=00.
REQ-042 window_len=10, err_num=3 on 5 words and 0 otherwise, en low for 4 cycles mid-window -> word_cnt=10, bit_cnt=80, err_cnt=15, status=00.
REQ-043 LOCK_TO=16, lock held 0 after start -> res_valid 16 cycles after entering WAIT_LOCK, status=01, all counts 0.
REQ-044 window_len=100, lock drops after 50 words -> status=10, word_cnt=50; abort with lock drop in the same cycle -> status=11.
REQ-045 res_ready held 0 for 10 cycles in REPORT -> outputs stable throughout; handshake then IDLE; start during REPORT ignored.
REQ-046 reset asserted at word 30 of MEASURE -> next cycle all outputs 0 and IDLE, no res_valid; a new start then runs normally.
